// File: rtl/nnrv_ram_arb.sv
// rtl/nnrv_ram_arb.sv - single-port RAM arbiter for fetch and load/store requesters.
// Data accesses win by default; a saturating counter lets fetch through after STARVE_LIMIT data grants.
module nnrv_ram_arb #(
   parameter int XLEN         = 64,
   parameter int ADDR_WIDTH   = 8,
   parameter int MASK_WIDTH   = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_if_req,
   input  logic [XLEN-1:0]       i_if_addr,
   input  logic [MASK_WIDTH-1:0] i_if_mask,
   input  logic                  i_if_flush,
   output logic                  o_if_gnt,
   output logic                  o_if_rvalid,
   output logic [XLEN-1:0]       o_if_rdata,
   input  logic                  i_mem_req,
   input  logic                  i_mem_we,
   input  logic [XLEN-1:0]       i_mem_addr,
   input  logic [MASK_WIDTH-1:0] i_mem_mask,
   input  logic [XLEN-1:0]       i_mem_wdata,
   output logic                  o_mem_gnt,
   output logic                  o_mem_rvalid,
   output logic [XLEN-1:0]       o_mem_rdata,
   output logic                  o_ram_en,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [MASK_WIDTH-1:0] o_ram_mask,
   output logic [XLEN-1:0]       o_ram_wdata,
   input  logic [XLEN-1:0]       i_ram_rdata,
   output logic                  o_busy
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [3:0]            starve_cnt_q, starve_cnt_d;
   logic                  starve_hit;
   logic                  if_gnt, mem_gnt;

   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [MASK_WIDTH-1:0] ram_mask_q, ram_mask_d;
   logic [XLEN-1:0]       ram_wdata_q, ram_wdata_d;

   // Read tags: valid, source (0 = fetch, 1 = data), flushed.
   logic                  s1_valid_q, s1_valid_d, s1_src_q, s1_src_d, s1_flush_q, s1_flush_d;
   logic                  s2_valid_q, s2_valid_d, s2_src_q, s2_src_d, s2_flush_q, s2_flush_d;

   logic [XLEN-1:0]       if_rdata_q, if_rdata_d;
   logic [XLEN-1:0]       mem_rdata_q, mem_rdata_d;

   assign starve_hit = (starve_cnt_q == STARVE_MAX);
   assign mem_gnt    = ~i_rst & i_mem_req & ~(i_if_req & starve_hit);
   assign if_gnt     = ~i_rst & i_if_req & (~i_mem_req | starve_hit);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (if_gnt || !i_if_req) begin
         starve_cnt_d = 4'd0;
      end else if (mem_gnt && !starve_hit) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   // Address, mask and write data hold when idle; only en/we drop.
   always_comb begin
      ram_en_d    = if_gnt | mem_gnt;
      ram_we_d    = mem_gnt & i_mem_we;
      ram_addr_d  = ram_addr_q;
      ram_mask_d  = ram_mask_q;
      ram_wdata_d = ram_wdata_q;
      if (mem_gnt) begin
         ram_addr_d  = i_mem_addr[ADDR_WIDTH-1:0];
         ram_mask_d  = i_mem_mask;
         ram_wdata_d = i_mem_wdata;
      end else if (if_gnt) begin
         ram_addr_d  = i_if_addr[ADDR_WIDTH-1:0];
         ram_mask_d  = i_if_mask;
         ram_wdata_d = '0;
      end
   end

   always_comb begin
      s1_valid_d  = if_gnt | (mem_gnt & ~i_mem_we);
      s1_src_d    = mem_gnt;
      s1_flush_d  = if_gnt & i_if_flush;
      s2_valid_d  = s1_valid_q;
      s2_src_d    = s1_src_q;
      s2_flush_d  = s1_flush_q | (i_if_flush & s1_valid_q & ~s1_src_q);
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if (s1_valid_q) begin
         if (s1_src_q) begin
            mem_rdata_d = i_ram_rdata;
         end else begin
            if_rdata_d = i_ram_rdata;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         starve_cnt_q <= '0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_mask_q   <= '0;
         ram_wdata_q  <= '0;
         s1_valid_q   <= 1'b0;
         s1_src_q     <= 1'b0;
         s1_flush_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_src_q     <= 1'b0;
         s2_flush_q   <= 1'b0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_mask_q   <= ram_mask_d;
         ram_wdata_q  <= ram_wdata_d;
         s1_valid_q   <= s1_valid_d;
         s1_src_q     <= s1_src_d;
         s1_flush_q   <= s1_flush_d;
         s2_valid_q   <= s2_valid_d;
         s2_src_q     <= s2_src_d;
         s2_flush_q   <= s2_flush_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
      end
   end

   assign o_if_gnt     = if_gnt;
   assign o_mem_gnt    = mem_gnt;
   assign o_ram_en     = ram_en_q;
   assign o_ram_we     = ram_we_q;
   assign o_ram_addr   = ram_addr_q;
   assign o_ram_mask   = ram_mask_q;
   assign o_ram_wdata  = ram_wdata_q;
   assign o_if_rvalid  = s2_valid_q & ~s2_src_q & ~s2_flush_q;
   assign o_mem_rvalid = s2_valid_q & s2_src_q;
   assign o_if_rdata   = if_rdata_q;
   assign o_mem_rdata  = mem_rdata_q;
   assign o_busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_nnrv_ram_arb.sv
// tb/tb_nnrv_ram_arb.sv - directed bench for nnrv_ram_arb with a combinational-read RAM model.
module tb_nnrv_ram_arb;

   logic        clk;
   logic        rst;
   logic        if_req, if_flush, if_gnt, if_rvalid;
   logic [63:0] if_addr, if_rdata;
   logic [7:0]  if_mask;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_mask;
   logic        ram_en, ram_we, busy;
   logic [7:0]  ram_addr, ram_mask;
   logic [63:0] ram_wdata, ram_rdata;

   logic [63:0] ram [256];
   logic        written [256];

   int n_checks = 0;
   int n_fail   = 0;

   nnrv_ram_arb dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_mask(if_mask), .i_if_flush(if_flush),
      .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
      .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_mask(mem_mask),
      .i_mem_wdata(mem_wdata), .o_mem_gnt(mem_gnt), .o_mem_rvalid(mem_rvalid), .o_mem_rdata(mem_rdata),
      .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_mask(ram_mask),
      .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] init_word(input logic [7:0] a);
      if (a == 8'h10) return 64'hA5;
      return 64'hC0DE_0000_0000_0000 | {56'h0, a};
   endfunction

   assign ram_rdata = written[ram_addr] ? ram[ram_addr] : init_word(ram_addr);

   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         logic [63:0] w;
         w = written[ram_addr] ? ram[ram_addr] : init_word(ram_addr);
         for (int b = 0; b < 8; b++)
            if (ram_mask[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
         ram[ram_addr]     <= w;
         written[ram_addr] <= 1'b1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0; mem_we = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_ram_en"}, ram_en, 0);
      check_eq({pfx, "_ram_we"}, ram_we, 0);
      check_eq({pfx, "_ram_addr"}, ram_addr, 0);
      check_eq({pfx, "_ram_mask"}, ram_mask, 0);
      check_eq({pfx, "_ram_wdata"}, ram_wdata, 0);
      check_eq({pfx, "_if_rvalid"}, if_rvalid, 0);
      check_eq({pfx, "_if_rdata"}, if_rdata, 0);
      check_eq({pfx, "_mem_rvalid"}, mem_rvalid, 0);
      check_eq({pfx, "_mem_rdata"}, mem_rdata, 0);
      check_eq({pfx, "_busy"}, busy, 0);
      check_eq({pfx, "_if_gnt"}, if_gnt, 0);
      check_eq({pfx, "_mem_gnt"}, mem_gnt, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) written[i] = 1'b0;
      rst = 1'b0;
      if_req = 1'b0; if_addr = '0; if_mask = '0; if_flush = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_mask = '0; mem_wdata = '0;
      #1 rst = 1'b1;
      if_req = 1'b1; if_addr = 64'h10; if_mask = 8'hFF;
      mem_req = 1'b1; mem_addr = 64'h30; mem_mask = 8'hFF;
      sample();
      check_reset_outputs("por");

      // Reset mid-stream with both requesters active
      step(); step();
      rst = 1'b0;
      sample();
      check_eq("rel_mem_gnt", mem_gnt, 1);
      check_eq("rel_if_gnt", if_gnt, 0);
      step();
      sample();
      check_eq("a1_mem_gnt", mem_gnt, 1);
      step();
      rst = 1'b1;
      sample();
      check_reset_outputs("mid");
      step();
      rst = 1'b0;
      sample();
      check_eq("post_mem_gnt", mem_gnt, 1);
      check_eq("post_if_gnt", if_gnt, 0);
      check_eq("post_mem_rvalid", mem_rvalid, 0);
      check_eq("post_if_rvalid", if_rvalid, 0);
      idle(4);

      // Single fetch
      if_req = 1'b1; if_addr = 64'h10; if_mask = 8'hFF;
      sample();
      check_eq("f_if_gnt", if_gnt, 1);
      check_eq("f_mem_gnt", mem_gnt, 0);
      step(); if_req = 1'b0;
      sample();
      check_eq("f_ram_en", ram_en, 1);
      check_eq("f_ram_we", ram_we, 0);
      check_eq("f_ram_addr", ram_addr, 8'h10);
      check_eq("f_busy", busy, 1);
      check_eq("f_if_rvalid_early", if_rvalid, 0);
      step();
      sample();
      check_eq("f_if_rvalid", if_rvalid, 1);
      check_eq("f_if_rdata", if_rdata, 64'hA5);
      check_eq("f_mem_rvalid", mem_rvalid, 0);
      check_eq("f_ram_en_idle", ram_en, 0);
      step();
      sample();
      check_eq("f_if_rvalid_after", if_rvalid, 0);
      idle(2);

      // Starvation guard: both held, pattern mem x4 then if
      if_req = 1'b1; if_addr = 64'h40; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h41;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) step();
         sample();
         check_eq($sformatf("starve_mem_gnt_%0d", i), mem_gnt, (i % 5) != 4);
         check_eq($sformatf("starve_if_gnt_%0d", i), if_gnt, (i % 5) == 4);
      end
      idle(4);

      // Write then read-after-write of the same word
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h20; mem_mask = 8'hFF; mem_wdata = 64'hDEAD;
      sample();
      check_eq("w_mem_gnt", mem_gnt, 1);
      step();
      mem_we = 1'b0; mem_wdata = 64'h0;
      sample();
      check_eq("r_mem_gnt", mem_gnt, 1);
      check_eq("w_ram_we", ram_we, 1);
      check_eq("w_ram_wdata", ram_wdata, 64'hDEAD);
      check_eq("w_ram_addr", ram_addr, 8'h20);
      step(); mem_req = 1'b0;
      sample();
      check_eq("w_no_rvalid", mem_rvalid, 0);
      check_eq("r_ram_we", ram_we, 0);
      step();
      sample();
      check_eq("raw_mem_rvalid", mem_rvalid, 1);
      check_eq("raw_mem_rdata", mem_rdata, 64'hDEAD);
      idle(3);

      // Flush two in-flight fetches; a later data read is unaffected
      if_req = 1'b1; if_addr = 64'h10;
      sample();
      check_eq("fl_gnt0", if_gnt, 1);
      step(); if_addr = 64'h18; if_flush = 1'b1;
      sample();
      check_eq("fl_gnt1", if_gnt, 1);
      step(); if_req = 1'b0; if_flush = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h30;
      sample();
      check_eq("fl_mem_gnt", mem_gnt, 1);
      check_eq("fl_if_rvalid_n2", if_rvalid, 0);
      step(); mem_req = 1'b0;
      sample();
      check_eq("fl_if_rvalid_n3", if_rvalid, 0);
      step();
      sample();
      check_eq("fl_mem_rvalid", mem_rvalid, 1);
      check_eq("fl_mem_rdata", mem_rdata, init_word(8'h30));
      check_eq("fl_if_rvalid_n4", if_rvalid, 0);
      idle(3);

      // Alternating fetch and data reads back-to-back
      for (int k = 0; k < 8; k++) begin
         if (k > 0) step();
         if_req = 1'b0; mem_req = 1'b0;
         if (k < 6) begin
            if (k % 2 == 0) begin
               if_req = 1'b1; if_addr = 64'(8'h60 + k);
            end else begin
               mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'(8'h70 + k);
            end
         end
         sample();
         if (k >= 1) check_eq($sformatf("alt_busy_%0d", k), busy, 1);
         if (k >= 2) begin
            if ((k - 2) % 2 == 0) begin
               check_eq($sformatf("alt_if_rvalid_%0d", k), if_rvalid, 1);
               check_eq($sformatf("alt_mem_rvalid_%0d", k), mem_rvalid, 0);
               check_eq($sformatf("alt_if_rdata_%0d", k), if_rdata, init_word(8'(8'h60 + k - 2)));
            end else begin
               check_eq($sformatf("alt_mem_rvalid_%0d", k), mem_rvalid, 1);
               check_eq($sformatf("alt_if_rvalid_%0d", k), if_rvalid, 0);
               check_eq($sformatf("alt_mem_rdata_%0d", k), mem_rdata, init_word(8'(8'h70 + k - 2)));
            end
         end
      end
      idle(1);
      sample();
      check_eq("alt_busy_end", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
